// File: rtl/seg_mux_pkg.sv
// Shared constants for the seven-segment display bus receiver: digit selects,
// legal segment codes, FSM encoding and the BCD-to-binary helper.
package seg_mux_pkg;

    localparam logic [2:0] DSEL_U     = 3'b110;
    localparam logic [2:0] DSEL_T     = 3'b101;
    localparam logic [2:0] DSEL_H     = 3'b011;
    localparam logic [2:0] DSEL_BLANK = 3'b111;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        WAIT_U = 2'd0,
        GOT_U  = 2'd1,
        GOT_T  = 2'd2
    } state_t;

    function automatic logic [9:0] bcd3_to_bin(input logic [3:0] h,
                                               input logic [3:0] t,
                                               input logic [3:0] u);
        return ({6'd0, h} * 10'd100) + ({6'd0, t} * 10'd10) + {6'd0, u};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder; code_ok is low for any pattern
// that is not one of the ten digit glyphs.
module seg7_decode
    import seg_mux_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       code_ok
);

    always_comb begin
        bcd     = 4'd0;
        code_ok = 1'b1;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: code_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_mux_rx.sv
// Receiver for the multiplexed 3-digit display bus: rebuilds units/tens/hundreds
// from the dsel/seg lines and publishes each complete, legal frame.
module seg_mux_rx
    import seg_mux_pkg::*;
#(
    parameter int SETTLE         = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] dsel,
    input  logic [6:0] seg,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [9:0] value,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= SETTLE_C) ? SETTLE_C : c + 4'd1;
    endfunction

    logic [2:0] dsel_q, dsel_prev_q;
    logic [6:0] seg_q, seg_prev_q;
    logic       first_q;
    logic [3:0] cnt_q, cnt_d;
    logic       load, strobe;

    // Input capture: everything downstream works on the registered copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsel_q      <= DSEL_BLANK;
            seg_q       <= 7'd0;
            dsel_prev_q <= DSEL_BLANK;
            seg_prev_q  <= 7'd0;
            first_q     <= 1'b1;
            cnt_q       <= 4'd0;
        end else begin
            dsel_q      <= dsel;
            seg_q       <= seg;
            dsel_prev_q <= dsel_q;
            seg_prev_q  <= seg_q;
            first_q     <= 1'b0;
            cnt_q       <= cnt_d;
        end
    end

    // Strobe once per dwell, on the cycle the count first reaches SETTLE
    assign load   = first_q || (dsel_q != dsel_prev_q) || (seg_q != seg_prev_q);
    assign cnt_d  = load ? 4'd1 : sat_inc(cnt_q);
    assign strobe = (cnt_d == SETTLE_C) && (load || (cnt_q != SETTLE_C));

    logic [6:0] seg_pos;
    logic [3:0] bcd;
    logic       code_ok;

    assign seg_pos = seg_q ^ {7{SEG_ACTIVE_LOW}};

    seg7_decode u_dec (
        .seg     (seg_pos),
        .bcd     (bcd),
        .code_ok (code_ok)
    );

    logic sel_u, sel_t, sel_h, sel_blank, sel_bad;

    assign sel_u     = (dsel_q == DSEL_U);
    assign sel_t     = (dsel_q == DSEL_T);
    assign sel_h     = (dsel_q == DSEL_H);
    assign sel_blank = (dsel_q == DSEL_BLANK);
    assign sel_bad   = !(sel_u || sel_t || sel_h || sel_blank);

    state_t     state_q;
    logic [3:0] units_buf_q, tens_buf_q;
    logic [3:0] units_q, tens_q, hundreds_q;
    logic [9:0] value_q;
    logic       frame_valid_q, frame_err_q;

    // Frame FSM: only legal, non-blank strobes advance it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_U;
            units_buf_q   <= 4'd0;
            tens_buf_q    <= 4'd0;
            units_q       <= 4'd0;
            tens_q        <= 4'd0;
            hundreds_q    <= 4'd0;
            value_q       <= 10'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            if (strobe && !sel_blank) begin
                if (sel_bad || !code_ok) begin
                    frame_err_q <= 1'b1;
                    state_q     <= WAIT_U;
                end else begin
                    case (state_q)
                        WAIT_U: begin
                            // T/H seen while hunting for a frame start are not errors
                            if (sel_u) begin
                                units_buf_q <= bcd;
                                state_q     <= GOT_U;
                            end
                        end
                        GOT_U: begin
                            if (sel_t) begin
                                tens_buf_q <= bcd;
                                state_q    <= GOT_T;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_U;
                            end
                        end
                        GOT_T: begin
                            if (sel_h) begin
                                units_q       <= units_buf_q;
                                tens_q        <= tens_buf_q;
                                hundreds_q    <= bcd;
                                value_q       <= bcd3_to_bin(bcd, tens_buf_q, units_buf_q);
                                frame_valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            state_q <= WAIT_U;
                        end
                        default: state_q <= WAIT_U;
                    endcase
                end
            end
        end
    end

    assign units       = units_q;
    assign tens        = tens_q;
    assign hundreds    = hundreds_q;
    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule
